my_sync_fifo_prog: RTL and testbench
====================================

Name: my_sync_fifo_prog

Overview:
Single-clock, parametrised FIFO with occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the single-domain successor to the dual-clock FIFO. It serves blocks whose producer and consumer share one clock but need early flow-control warnings. Optional first-word-fall-through read mode.

Parameters:
MyDepthSize, 8, data word width in bits
MyArraySize, 4, address width; FIFO depth = 2**MyArraySize (16 by default)

Ports:
myClk  input  1  clock; all state updates on rising edge
myRst  input  1  reset, asynchronous, active-high
myWreq  input  1  write request
myWdata  input  MyDepthSize  write data
myRreq  input  1  read request
myRdata  output  MyDepthSize  read data
myWfull  output  1  count == depth
myRempty  output  1  count == 0
myCount  output  MyArraySize+1  current occupancy, 0..depth
myAfullThr  input  MyArraySize+1  almost-full threshold
myAemptyThr  input  MyArraySize+1  almost-empty threshold
myAfull  output  1  almost full
myAempty  output  1  almost empty
myClrErr  input  1  synchronous clear of sticky error flags
myOvf  output  1  sticky overflow
myUdf  output  1  sticky underflow

Behaviour:
- One clock, myClk; reset myRst is asynchronous and active-high. Asserting myRst immediately clears wptr, rptr, count, myRdata and the error flags. Memory contents are not cleared.
- Reset values: myCount=0, myRempty=1, myWfull=0, myRdata=0, myOvf=0, myUdf=0, myAempty=1, myAfull=(myAfullThr==0).
- Write accepted iff myWreq && !myWfull. On acceptance: mem[wptr]<=myWdata and wptr increments, wrapping modulo depth.
- Read accepted iff myRreq && !myRempty. On acceptance rptr increments, wrapping modulo depth.
- Standard mode: myRdata is registered and shows mem[rptr] on the cycle after the accepted read (1-cycle latency). myRdata holds its value when no read is accepted.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- At full, a simultaneous write is rejected even if a read is accepted in the same cycle. No write-through at full.
- At empty, a simultaneous read is rejected. No read-through at empty.
- Count update: +1 on write-only, -1 on read-only, otherwise unchanged.
- myWfull, myRempty, myAfull and myAempty are combinational from the registered count.
- myAfull = (count >= myAfullThr); myAempty = (count <= myAemptyThr). Comparisons are unsigned at MyArraySize+1 bits. Thresholds are sampled live; changing one takes effect in the same cycle.
- myOvf sets on myWreq && myWfull; myUdf sets on myRreq && myRempty. Each stays set until myClrErr or reset.
- If myClrErr and a set condition occur in the same cycle, the set wins.
- No state machine beyond pointer/count registers. Pointers carry no extra wrap bit; full and empty come from the count.

Optional Feature:
MY_FIFO_FWFT_EN defined: first-word-fall-through mode.
- myRdata continuously shows mem[rptr] while !myRempty; myRreq pops the head.
- Data for the first write appears on myRdata one cycle after the write clock edge, and myRempty deasserts in that same cycle.
- myRdata is don't-care while empty. The bench checks it only when !myRempty.
MY_FIFO_FWFT_EN not defined: standard registered 1-cycle-latency read as above.
All flags, count and error behaviour are identical in both modes.

Decomposition:
- Package my_fifo_pkg: default width and address-size constants; a function computing depth from address size; a count-width constant (MyArraySize+1).
- One natural sub-module: my_fifo_ram, a simple dual-port register array with synchronous write and combinational or registered read, selected by the mode. Pointer, count and flag logic stays in the top level.

Test Plan:
- After reset, write 1..16 on consecutive cycles, then read 16. Required: myWfull=1 and myCount=16 after the 16th write; reads return 1..16 in order; myRempty=1 at the end; no error flags set.
- With the FIFO full, one more write of 8'd99. Required: myOvf=1, myCount stays 16, and 99 is never read back. Then pulse myClrErr. Required: myOvf=0.
- With the FIFO empty, assert myRreq. Required: myUdf=1, myCount=0, myRdata unchanged (standard mode).
- Fill to 8, then issue 10 cycles of simultaneous read and write. Required: myCount stays 8 throughout and data stays in order. Repeat at full (count 16). Required: write rejected, count drops to 15.
- With myAfullThr=12 and myAemptyThr=3, fill from 0 to 16. Required: myAempty deasserts at count 4; myAfull asserts at count 12.
- Assert myRst mid-stream at count 5. Required: outputs return to reset values immediately, without waiting for a clock edge. In FWFT build, also check that the first write after reset shows on myRdata one cycle later with myRempty=0.

Source files
------------

// File: rtl/my_fifo_pkg.sv
// ---------------------------------------------------------------------------
// my_fifo_pkg
// Shared constants and helpers for the single-clock programmable FIFO.
//   MY_DEFAULT_WIDTH  : default data word width in bits
//   MY_DEFAULT_ASIZE  : default address width (depth = 2**asize)
//   MY_DEFAULT_CNT_W  : default occupancy-count width (asize + 1)
//   fifo_depth()      : depth derived from an address width
//   fifo_cnt_width()  : count width derived from an address width
// Build option: MY_FIFO_FWFT_EN (first-word-fall-through read mode) is
// consumed by my_fifo_ram; nothing in this package depends on it.
// ---------------------------------------------------------------------------
package my_fifo_pkg;

  localparam int MY_DEFAULT_WIDTH = 8;
  localparam int MY_DEFAULT_ASIZE = 4;
  localparam int MY_DEFAULT_CNT_W = MY_DEFAULT_ASIZE + 1;

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  // One extra bit so the count can represent both 0 and a full FIFO.
  function automatic int fifo_cnt_width(input int asize);
    return asize + 1;
  endfunction

endpackage

// File: rtl/my_fifo_ram.sv
// ---------------------------------------------------------------------------
// my_fifo_ram
// Simple dual-port register array backing the FIFO.
//   clk   : write (and registered read) clock
//   rst   : async active-high reset of the read-data register only
//   we    : write enable, waddr/wdata : write port
//   re    : read enable (advances the registered read data)
//   raddr : read address, rdata : read data
// Build option MY_FIFO_FWFT_EN:
//   defined     -> rdata is a combinational view of mem[raddr]
//   not defined -> rdata is registered, loaded from mem[raddr] when re=1 and
//                  held otherwise; cleared by rst
// The storage array itself is never reset.
// ---------------------------------------------------------------------------
module my_fifo_ram
  import my_fifo_pkg::*;
#(
  parameter int Width = MY_DEFAULT_WIDTH,
  parameter int AddrW = MY_DEFAULT_ASIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  localparam int Depth = fifo_depth(AddrW);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef MY_FIFO_FWFT_EN
  // The head word is always visible; reset and read enable play no part.
  logic unused_ram_inputs;
  assign unused_ram_inputs = ^{rst, re};
  assign rdata = mem[raddr];
`else
  logic [Width-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: rtl/my_sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// my_sync_fifo_prog
// Single-clock FIFO with occupancy count, programmable almost-full /
// almost-empty thresholds and sticky overflow / underflow flags.
//   myClk, myRst           : clock, async active-high reset
//   myWreq, myWdata        : write request and data
//   myRreq, myRdata        : read request and data
//   myWfull, myRempty      : count == depth / count == 0
//   myCount                : occupancy 0..depth
//   myAfullThr, myAfull    : almost-full threshold, count >= threshold
//   myAemptyThr, myAempty  : almost-empty threshold, count <= threshold
//   myClrErr               : synchronous clear of sticky flags
//   myOvf, myUdf           : sticky overflow / underflow
// Build option MY_FIFO_FWFT_EN selects first-word-fall-through reads (see
// my_fifo_ram); flags, count and error behaviour do not depend on it.
// ---------------------------------------------------------------------------
module my_sync_fifo_prog
  import my_fifo_pkg::*;
#(
  parameter int MyDepthSize = MY_DEFAULT_WIDTH,
  parameter int MyArraySize = MY_DEFAULT_ASIZE
) (
  input  logic                   myClk,
  input  logic                   myRst,
  input  logic                   myWreq,
  input  logic [MyDepthSize-1:0] myWdata,
  input  logic                   myRreq,
  output logic [MyDepthSize-1:0] myRdata,
  output logic                   myWfull,
  output logic                   myRempty,
  output logic [MyArraySize:0]   myCount,
  input  logic [MyArraySize:0]   myAfullThr,
  input  logic [MyArraySize:0]   myAemptyThr,
  output logic                   myAfull,
  output logic                   myAempty,
  input  logic                   myClrErr,
  output logic                   myOvf,
  output logic                   myUdf
);

  localparam int CntW = fifo_cnt_width(MyArraySize);
  localparam logic [CntW-1:0] DepthCnt = CntW'(fifo_depth(MyArraySize));

  logic [MyArraySize-1:0] wptr_d, wptr_q;
  logic [MyArraySize-1:0] rptr_d, rptr_q;
  logic [CntW-1:0]        count_d, count_q;
  logic                   ovf_d, ovf_q;
  logic                   udf_d, udf_q;
  logic                   wr_acc, rd_acc;

  // Acceptance looks only at the registered flags, so a read at full never
  // frees a slot for a same-cycle write and a write at empty never feeds a
  // same-cycle read.
  always_comb begin
    wr_acc  = myWreq && !myWfull;
    rd_acc  = myRreq && !myRempty;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;

    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set is evaluated after clear so a coincident error still sticks.
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (myClrErr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (myWreq && myWfull)  ovf_d = 1'b1;
    if (myRreq && myRempty) udf_d = 1'b1;
  end

  always_ff @(posedge myClk or posedge myRst) begin
    if (myRst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign myCount  = count_q;
  assign myWfull  = (count_q == DepthCnt);
  assign myRempty = (count_q == '0);
  assign myAfull  = (count_q >= myAfullThr);
  assign myAempty = (count_q <= myAemptyThr);
  assign myOvf    = ovf_q;
  assign myUdf    = udf_q;

  my_fifo_ram #(
    .Width (MyDepthSize),
    .AddrW (MyArraySize)
  ) u_ram (
    .clk   (myClk),
    .rst   (myRst),
    .we    (wr_acc),
    .waddr (wptr_q),
    .wdata (myWdata),
    .re    (rd_acc),
    .raddr (rptr_q),
    .rdata (myRdata)
  );

endmodule

// File: tb/tb_my_sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// tb_my_sync_fifo_prog
// Directed self-checking bench for my_sync_fifo_prog (depth 16, 8-bit data).
// Honours MY_FIFO_FWFT_EN: read data is checked before the popping edge in
// FWFT builds and one cycle after the accepted read otherwise.
// ---------------------------------------------------------------------------
module tb_my_sync_fifo_prog;

  logic       myClk;
  logic       myRst;
  logic       myWreq;
  logic [7:0] myWdata;
  logic       myRreq;
  logic [7:0] myRdata;
  logic       myWfull;
  logic       myRempty;
  logic [4:0] myCount;
  logic [4:0] myAfullThr;
  logic [4:0] myAemptyThr;
  logic       myAfull;
  logic       myAempty;
  logic       myClrErr;
  logic       myOvf;
  logic       myUdf;

  int vectors;
  int miscompares;

  my_sync_fifo_prog #(
    .MyDepthSize (8),
    .MyArraySize (4)
  ) dut (
    .myClk       (myClk),
    .myRst       (myRst),
    .myWreq      (myWreq),
    .myWdata     (myWdata),
    .myRreq      (myRreq),
    .myRdata     (myRdata),
    .myWfull     (myWfull),
    .myRempty    (myRempty),
    .myCount     (myCount),
    .myAfullThr  (myAfullThr),
    .myAemptyThr (myAemptyThr),
    .myAfull     (myAfull),
    .myAempty    (myAempty),
    .myClrErr    (myClrErr),
    .myOvf       (myOvf),
    .myUdf       (myUdf)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  initial myClk = 1'b0;
  always #5 myClk = ~myClk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of requests, cross the rising edge, settle, then idle.
  task automatic applyStimulus(input logic wreq, input logic [7:0] wdata,
                               input logic rreq, input logic clr);
    myWreq   = wreq;
    myWdata  = wdata;
    myRreq   = rreq;
    myClrErr = clr;
    @(posedge myClk);
    #1;
    myWreq   = 1'b0;
    myRreq   = 1'b0;
    myClrErr = 1'b0;
  endtask

  // Directed sequence: reset, fill/drain, errors, concurrency, thresholds,
  // asynchronous reset mid-stream.
  initial begin
    vectors     = 0;
    miscompares = 0;
    myRst       = 1'b1;
    myWreq      = 1'b0;
    myWdata     = 8'd0;
    myRreq      = 1'b0;
    myClrErr    = 1'b0;
    myAfullThr  = 5'd0;
    myAemptyThr = 5'd0;

    #12;
    checkOutput("rst_count", myCount, 0);
    checkOutput("rst_empty", myRempty, 1);
    checkOutput("rst_full", myWfull, 0);
`ifndef MY_FIFO_FWFT_EN
    checkOutput("rst_rdata", myRdata, 0);
`endif
    checkOutput("rst_ovf", myOvf, 0);
    checkOutput("rst_udf", myUdf, 0);
    checkOutput("rst_aempty", myAempty, 1);
    checkOutput("rst_afull_thr0", myAfull, 1);
    myAfullThr = 5'd16;
    #1;
    checkOutput("rst_afull_thr16", myAfull, 0);

    @(posedge myClk);
    #1;
    myRst = 1'b0;

    // Fill with 1..16.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      checkOutput("fill_count", myCount, i);
    end
    checkOutput("fill_full", myWfull, 1);
    checkOutput("fill_ovf", myOvf, 0);

    // Overflow attempt at full.
    applyStimulus(1'b1, 8'd99, 1'b0, 1'b0);
    checkOutput("ovf_set", myOvf, 1);
    checkOutput("ovf_count", myCount, 16);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    checkOutput("ovf_clr", myOvf, 0);

    // Drain: 1..16 in order, 99 never appears.
    for (int i = 1; i <= 16; i++) begin
`ifdef MY_FIFO_FWFT_EN
      checkOutput("drain_rdata", myRdata, i);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
`else
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
      checkOutput("drain_rdata", myRdata, i);
`endif
    end
    checkOutput("drain_empty", myRempty, 1);
    checkOutput("drain_count", myCount, 0);
    checkOutput("drain_ovf", myOvf, 0);
    checkOutput("drain_udf", myUdf, 0);

    // Underflow at empty.
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("udf_set", myUdf, 1);
    checkOutput("udf_count", myCount, 0);
`ifndef MY_FIFO_FWFT_EN
    checkOutput("udf_rdata_hold", myRdata, 16);
`endif
    // Clear coinciding with a fresh underflow: the set wins.
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    checkOutput("udf_set_wins", myUdf, 1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    checkOutput("udf_clr", myUdf, 0);

    // Fill to 8 with 20..27, then 10 cycles of read+write (writes 28..37).
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(20 + i), 1'b0, 1'b0);
    checkOutput("half_count", myCount, 8);
    for (int k = 0; k < 10; k++) begin
`ifdef MY_FIFO_FWFT_EN
      checkOutput("rw_rdata", myRdata, 20 + k);
      applyStimulus(1'b1, 8'(28 + k), 1'b1, 1'b0);
`else
      applyStimulus(1'b1, 8'(28 + k), 1'b1, 1'b0);
      checkOutput("rw_rdata", myRdata, 20 + k);
`endif
      checkOutput("rw_count", myCount, 8);
    end

    // Top up with 38..45 to reach full; contents are now 30..45.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(38 + i), 1'b0, 1'b0);
    checkOutput("top_full", myWfull, 1);

    // Read+write at full: write of 200 rejected, count falls to 15.
`ifdef MY_FIFO_FWFT_EN
    checkOutput("rwfull_rdata", myRdata, 30);
    applyStimulus(1'b1, 8'd200, 1'b1, 1'b0);
`else
    applyStimulus(1'b1, 8'd200, 1'b1, 1'b0);
    checkOutput("rwfull_rdata", myRdata, 30);
`endif
    checkOutput("rwfull_count", myCount, 15);
    checkOutput("rwfull_ovf", myOvf, 1);
    for (int j = 0; j < 15; j++) begin
`ifdef MY_FIFO_FWFT_EN
      checkOutput("rwfull_drain", myRdata, 31 + j);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
`else
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
      checkOutput("rwfull_drain", myRdata, 31 + j);
`endif
    end
    checkOutput("rwfull_empty", myRempty, 1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    checkOutput("rwfull_ovf_clr", myOvf, 0);

    // Thresholds: aempty while count <= 3, afull once count >= 12.
    myAfullThr  = 5'd12;
    myAemptyThr = 5'd3;
    #1;
    checkOutput("thr_aempty0", myAempty, 1);
    checkOutput("thr_afull0", myAfull, 0);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(50 + i), 1'b0, 1'b0);
      checkOutput("thr_aempty", myAempty, (i <= 3) ? 1 : 0);
      checkOutput("thr_afull", myAfull, (i >= 12) ? 1 : 0);
    end
    myAfullThr = 5'd17;
    #1;
    checkOutput("thr_live17", myAfull, 0);
    myAfullThr = 5'd12;
    #1;
    checkOutput("thr_live12", myAfull, 1);

    // Set ovf, then drain 11 (values 51..61) down to count 5.
    applyStimulus(1'b1, 8'd7, 1'b0, 1'b0);
    checkOutput("pre_rst_ovf", myOvf, 1);
    for (int j = 0; j < 11; j++) begin
`ifdef MY_FIFO_FWFT_EN
      checkOutput("pre_rst_rdata", myRdata, 51 + j);
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
`else
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
      checkOutput("pre_rst_rdata", myRdata, 51 + j);
`endif
    end
    checkOutput("pre_rst_count", myCount, 5);

    // Asynchronous reset between clock edges.
    #3;
    myRst = 1'b1;
    #1;
    checkOutput("arst_count", myCount, 0);
    checkOutput("arst_empty", myRempty, 1);
    checkOutput("arst_full", myWfull, 0);
`ifndef MY_FIFO_FWFT_EN
    checkOutput("arst_rdata", myRdata, 0);
`endif
    checkOutput("arst_ovf", myOvf, 0);
    checkOutput("arst_udf", myUdf, 0);
    checkOutput("arst_aempty", myAempty, 1);
    checkOutput("arst_afull", myAfull, 0);
    @(posedge myClk);
    #1;
    myRst = 1'b0;

    // First write after reset.
    applyStimulus(1'b1, 8'd77, 1'b0, 1'b0);
    checkOutput("post_rst_empty", myRempty, 0);
    checkOutput("post_rst_count", myCount, 1);
`ifdef MY_FIFO_FWFT_EN
    checkOutput("post_rst_fwft", myRdata, 77);
`else
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);
    checkOutput("post_rst_rdata", myRdata, 77);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
